// File: rtl/mode_accumulator_pkg.sv
// Shared constants and FSM state type for the mode_accumulator block.
package mode_accumulator_pkg;

  // Term operation selectors for the MODE parameter.
  localparam int unsigned MODE_ADD = 0;
  localparam int unsigned MODE_MUL = 1;
  localparam int unsigned MODE_SUB = 2;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

endpackage

// File: rtl/mode_accumulator_if.sv
// Sample-in / result-out bundle of the mode_accumulator block.
interface mode_accumulator_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_x, in_y, in_abort, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_abort, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/mode_accumulator_term.sv
// Combinational term unit: reduces (x, y) to one term using the MODE operation.
// Define MODE_ACCUMULATOR_SAT_EN for unsigned saturation instead of modulo wrap.
module mode_accumulator_term
  import mode_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 0
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] term_o
);

  if (MODE == MODE_ADD) begin : g_add
`ifdef MODE_ACCUMULATOR_SAT_EN
    logic [WIDTH:0] sum;
    assign sum    = {1'b0, x_i} + {1'b0, y_i};
    assign term_o = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    assign term_o = x_i + y_i;
`endif
  end else if (MODE == MODE_MUL) begin : g_mul
`ifdef MODE_ACCUMULATOR_SAT_EN
    logic [2*WIDTH-1:0] prod;
    assign prod   = {{WIDTH{1'b0}}, x_i} * {{WIDTH{1'b0}}, y_i};
    assign term_o = (|prod[2*WIDTH-1:WIDTH]) ? '1 : prod[WIDTH-1:0];
`else
    // Product is evaluated at WIDTH bits, keeping only the low half.
    assign term_o = x_i * y_i;
`endif
  end else if (MODE == MODE_SUB) begin : g_sub
`ifdef MODE_ACCUMULATOR_SAT_EN
    assign term_o = (y_i > x_i) ? '0 : x_i - y_i;
`else
    assign term_o = x_i - y_i;
`endif
  end else begin : g_bad_mode
    $error("mode_accumulator_term: MODE must be 0, 1 or 2");
  end

endmodule

// File: rtl/mode_accumulator.sv
// Streaming accumulator: sums COUNT terms per frame, result on a valid/ready port.
// Define MODE_ACCUMULATOR_SAT_EN for saturating (unsigned) term and accumulation.
module mode_accumulator
  import mode_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 0,
  parameter int unsigned COUNT = 4
) (
  input logic                clk,
  input logic                rst_n,
  mode_accumulator_if.slave  bus
);

  localparam int unsigned CntW = $clog2(COUNT + 1);

  if (COUNT < 1) begin : g_bad_count
    $error("mode_accumulator: COUNT must be >= 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] acc_next;
  logic             in_ready;
  logic             accept;
  logic             load_first;

  mode_accumulator_term #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_term (
    .x_i    (bus.in_x),
    .y_i    (bus.in_y),
    .term_o (term)
  );

`ifdef MODE_ACCUMULATOR_SAT_EN
  logic [WIDTH:0] acc_wide;
  assign acc_wide = {1'b0, acc_q} + {1'b0, term};
  assign acc_next = acc_wide[WIDTH] ? '1 : acc_wide[WIDTH-1:0];
`else
  assign acc_next = acc_q + term;
`endif

  // A held result only blocks input while downstream is stalling it.
  assign in_ready = (state_q != StHold) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Next-state: frame sequencing, abort handling and result hand-off.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    load_first  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_abort) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          load_first = 1'b1;
        end
      end
      StAccum: begin
        if (bus.in_abort) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (accept) begin
          if (cnt_q == CntW'(COUNT - 1)) begin
            out_data_d  = acc_next;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = StHold;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        // Abort never touches the pending result; it only drops a coincident sample.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
          load_first  = accept && !bus.in_abort;
        end
      end
      default: state_d = StIdle;
    endcase

    // First sample of a frame loads rather than accumulates.
    if (load_first) begin
      if (COUNT == 1) begin
        out_data_d  = term;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end else begin
        acc_d   = term;
        cnt_d   = CntW'(1);
        state_d = StAccum;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == StAccum) || (state_q == StHold);

endmodule

// File: tb/tb_mode_accumulator.sv
// Bench for mode_accumulator: four WIDTH=8 instances covering add/mul/sub and COUNT=1/2/4.
module tb_mode_accumulator;

  localparam longint MaxV = 255;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mode_accumulator_if #(.WIDTH(8)) i0 ();
  mode_accumulator_if #(.WIDTH(8)) i1 ();
  mode_accumulator_if #(.WIDTH(8)) i2 ();
  mode_accumulator_if #(.WIDTH(8)) i3 ();

  mode_accumulator #(.WIDTH(8), .MODE(0), .COUNT(4)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  mode_accumulator #(.WIDTH(8), .MODE(1), .COUNT(2)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  mode_accumulator #(.WIDTH(8), .MODE(0), .COUNT(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  mode_accumulator #(.WIDTH(8), .MODE(2), .COUNT(1)) d3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

  // Reference arithmetic: exact integer result, then wrap or clamp to 8 bits.
  function automatic longint fit(longint v);
`ifdef MODE_ACCUMULATOR_SAT_EN
    if (v > MaxV) return MaxV;
    if (v < 0) return 0;
    return v;
`else
    return v & MaxV;
`endif
  endfunction

  function automatic longint ref_term(int mode, longint x, longint y);
    case (mode)
      0:       return fit(x + y);
      1:       return fit(x * y);
      default: return fit(x - y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i0.in_valid = 0; i0.in_abort = 0; i0.out_ready = 1; i0.in_x = 0; i0.in_y = 0;
    i1.in_valid = 0; i1.in_abort = 0; i1.out_ready = 1; i1.in_x = 0; i1.in_y = 0;
    i2.in_valid = 0; i2.in_abort = 0; i2.out_ready = 1; i2.in_x = 0; i2.in_y = 0;
    i3.in_valid = 0; i3.in_abort = 0; i3.out_ready = 1; i3.in_x = 0; i3.in_y = 0;
    #12;
    n_checks++;
    if ({i0.out_valid, i0.busy, i0.out_data} !== 10'd0) begin
      n_fail++; $display("FAIL reset_d0: got %b want 0", {i0.out_valid, i0.busy, i0.out_data});
    end
    n_checks++;
    if ({i1.out_valid, i1.busy, i1.out_data} !== 10'd0) begin
      n_fail++; $display("FAIL reset_d1: got %b want 0", {i1.out_valid, i1.busy, i1.out_data});
    end
    n_checks++;
    if ({i2.out_valid, i2.busy, i2.out_data} !== 10'd0) begin
      n_fail++; $display("FAIL reset_d2: got %b want 0", {i2.out_valid, i2.busy, i2.out_data});
    end
    n_checks++;
    if ({i3.out_valid, i3.busy, i3.out_data} !== 10'd0) begin
      n_fail++; $display("FAIL reset_d3: got %b want 0", {i3.out_valid, i3.busy, i3.out_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (i0.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", i0.in_ready);
    end
  endtask

  task automatic test_add_frame();
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    longint     acc;
    xs = '{8'd1, 8'd3, 8'd5, 8'd7};
    ys = '{8'd2, 8'd4, 8'd6, 8'd8};
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      i0.in_valid = 1; i0.in_x = xs[k]; i0.in_y = ys[k];
      step();
      acc = (k == 0) ? ref_term(0, xs[k], ys[k]) : fit(acc + ref_term(0, xs[k], ys[k]));
      if (k < 3) begin
        n_checks++;
        if ({i0.out_valid, i0.busy} !== 2'b01) begin
          n_fail++; $display("FAIL add_mid%0d: valid,busy=%b want 01", k, {i0.out_valid, i0.busy});
        end
      end
    end
    i0.in_valid = 0;
    n_checks++;
    if (i0.out_valid !== 1'b1 || i0.out_data !== 8'(acc)) begin
      n_fail++; $display("FAIL add_result: valid=%b data=%0d want 1/%0d", i0.out_valid, i0.out_data, acc);
    end
    step();
    n_checks++;
    if ({i0.out_valid, i0.busy} !== 2'b00) begin
      n_fail++; $display("FAIL add_drain: valid,busy=%b want 00", {i0.out_valid, i0.busy});
    end
  endtask

  task automatic test_mul_frame();
    longint exp_v;
    exp_v = fit(ref_term(1, 16, 16) + ref_term(1, 3, 5));
    i1.in_valid = 1; i1.in_x = 16; i1.in_y = 16;
    step();
    i1.in_x = 3; i1.in_y = 5;
    step();
    i1.in_valid = 0;
    n_checks++;
    if (i1.out_valid !== 1'b1 || i1.out_data !== 8'(exp_v)) begin
      n_fail++; $display("FAIL mul_result: valid=%b data=%0d want 1/%0d", i1.out_valid, i1.out_data, exp_v);
    end
    step();
  endtask

  task automatic test_wrap_frame();
    longint exp_v;
    exp_v = fit(ref_term(0, 200, 50) + ref_term(0, 10, 0));
    i2.in_valid = 1; i2.in_x = 200; i2.in_y = 50;
    step();
    i2.in_x = 10; i2.in_y = 0;
    step();
    i2.in_valid = 0;
    n_checks++;
    if (i2.out_valid !== 1'b1 || i2.out_data !== 8'(exp_v)) begin
      n_fail++; $display("FAIL wrap_result: valid=%b data=%0d want 1/%0d", i2.out_valid, i2.out_data, exp_v);
    end
    step();
  endtask

  task automatic test_hold_stall();
    longint first_v, second_v;
    first_v  = ref_term(2, 20, 7);
    second_v = ref_term(2, 9, 4);
    i3.out_ready = 0; i3.in_valid = 1; i3.in_x = 20; i3.in_y = 7;
    step();
    i3.in_x = 33; i3.in_y = 1;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (i3.in_ready !== 1'b0 || i3.out_valid !== 1'b1 || i3.out_data !== 8'(first_v)) begin
        n_fail++;
        $display("FAIL hold_stall%0d: rdy=%b valid=%b data=%0d want 0/1/%0d",
                 c, i3.in_ready, i3.out_valid, i3.out_data, first_v);
      end
      step();
    end
    i3.out_ready = 1; i3.in_x = 9; i3.in_y = 4;
    #1;
    n_checks++;
    if (i3.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release_rdy: got %b want 1", i3.in_ready);
    end
    step();
    i3.in_valid = 0;
    n_checks++;
    if (i3.out_valid !== 1'b1 || i3.out_data !== 8'(second_v)) begin
      n_fail++; $display("FAIL hold_b2b: valid=%b data=%0d want 1/%0d", i3.out_valid, i3.out_data, second_v);
    end
    step();
    n_checks++;
    if (i3.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_drain: valid=%b want 0", i3.out_valid);
    end
  endtask

  task automatic test_abort();
    longint acc;
    i0.out_ready = 1;
    i0.in_valid = 1; i0.in_x = 2; i0.in_y = 3;
    step();
    i0.in_x = 4; i0.in_y = 5;
    step();
    i0.in_abort = 1; i0.in_x = 50; i0.in_y = 50;
    step();
    i0.in_abort = 0;
    n_checks++;
    if (i0.busy !== 1'b0 || d0.cnt_q !== '0 || i0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_clear: busy=%b cnt=%0d valid=%b want 0/0/0", i0.busy, d0.cnt_q, i0.out_valid);
    end
    acc = 0;
    i0.in_x = 1; i0.in_y = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      acc = (k == 0) ? ref_term(0, 1, 1) : fit(acc + ref_term(0, 1, 1));
    end
    i0.in_valid = 0;
    n_checks++;
    if (i0.out_valid !== 1'b1 || i0.out_data !== 8'(acc)) begin
      n_fail++; $display("FAIL abort_next: valid=%b data=%0d want 1/%0d", i0.out_valid, i0.out_data, acc);
    end
    step();
  endtask

  task automatic test_async_reset();
    longint acc;
    i0.in_valid = 1; i0.in_x = 9; i0.in_y = 9;
    step();
    step();
    i0.in_valid = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({i0.out_valid, i0.busy, i0.out_data} !== 10'd0) begin
      n_fail++; $display("FAIL async_reset: got %b want 0", {i0.out_valid, i0.busy, i0.out_data});
    end
    #2;
    rst_n = 1'b1;
    step();
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      i0.in_valid = 1; i0.in_x = 8'(10 + 20 * k); i0.in_y = 8'(20 + 20 * k);
      step();
      acc = (k == 0) ? ref_term(0, 10, 20) : fit(acc + ref_term(0, 10 + 20 * k, 20 + 20 * k));
    end
    i0.in_valid = 0;
    n_checks++;
    if (i0.out_valid !== 1'b1 || i0.out_data !== 8'(acc)) begin
      n_fail++; $display("FAIL reset_next: valid=%b data=%0d want 1/%0d", i0.out_valid, i0.out_data, acc);
    end
    step();
  endtask

  // Random gaps, frames back to back with out_ready held high.
  task automatic test_back_to_back();
    longint acc;
    int     cnt, frames;
    logic   exp_valid;
    cnt = 0; frames = 0; acc = 0;
    i0.out_ready = 1;
    for (int c = 0; c < 300 && frames < 8; c++) begin
      i0.in_valid = ($urandom_range(0, 3) != 0);
      i0.in_x = 8'($urandom); i0.in_y = 8'($urandom);
      step();
      exp_valid = 1'b0;
      if (i0.in_valid) begin
        acc = (cnt == 0) ? ref_term(0, i0.in_x, i0.in_y) : fit(acc + ref_term(0, i0.in_x, i0.in_y));
        cnt++;
        if (cnt == 4) begin
          exp_valid = 1'b1; cnt = 0; frames++;
        end
      end
      n_checks++;
      if (i0.out_valid !== exp_valid || (exp_valid && i0.out_data !== 8'(acc))) begin
        n_fail++;
        $display("FAIL b2b_c%0d: valid=%b data=%0d want %b/%0d", c, i0.out_valid, i0.out_data, exp_valid, acc);
      end
    end
    i0.in_valid = 0;
    n_checks++;
    if (frames != 8) begin
      n_fail++; $display("FAIL b2b_frames: got %0d want 8", frames);
    end
    step();
  endtask

  // COUNT=1 subtractor as a one-entry result slot under random stalls and aborts.
  task automatic test_random_sub();
    logic       pend_v, exp_rdy, acc_now;
    logic [7:0] pend_d;
    pend_v = 1'b0; pend_d = '0;
    for (int c = 0; c < 150; c++) begin
      i3.in_valid  = 1'($urandom_range(0, 1));
      i3.in_x      = 8'($urandom);
      i3.in_y      = 8'($urandom);
      i3.in_abort  = ($urandom_range(0, 7) == 0);
      i3.out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !pend_v || i3.out_ready;
      n_checks++;
      if (i3.in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL sub_rdy_c%0d: got %b want %b", c, i3.in_ready, exp_rdy);
      end
      acc_now = i3.in_valid && exp_rdy && !i3.in_abort;
      step();
      if (pend_v && i3.out_ready) pend_v = 1'b0;
      if (acc_now) begin
        pend_v = 1'b1;
        pend_d = 8'(ref_term(2, i3.in_x, i3.in_y));
      end
      n_checks++;
      if (i3.out_valid !== pend_v || (pend_v && i3.out_data !== pend_d)) begin
        n_fail++;
        $display("FAIL sub_out_c%0d: valid=%b data=%0d want %b/%0d", c, i3.out_valid, i3.out_data, pend_v, pend_d);
      end
    end
    i3.in_valid = 0; i3.in_abort = 0; i3.out_ready = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_add_frame();
    test_mul_frame();
    test_wrap_frame();
    test_hold_stall();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random_sub();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_accumulator.md
Name: mode_accumulator

Overview:
- Parametrised streaming arithmetic accumulator; the next generation of the team's constant-mode arithmetic block.
- Each accepted sample pair (x, y) is reduced to a term by a parameter-selected operation (add / multiply / subtract), resolved at elaboration via generate-if.
- Terms are accumulated over COUNT samples; the result is emitted on a valid/ready output port.
- Serves as a lint/transform regression vehicle and as a reusable datapath leaf.

Parameters:
- WIDTH, 32: data width of x, y, term, accumulator and output.
- MODE, 0: term operation. 0 = x+y, 1 = x*y, 2 = x-y. Any other value is an elaboration error.
- COUNT, 4: samples per result; must be >= 1 (elaboration error otherwise).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_x  input  WIDTH  operand x (unsigned).
- in_y  input  WIDTH  operand y (unsigned).
- in_abort  input  1  synchronous frame abort.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  accumulated result.
- busy  output  1  frame in progress (cnt != 0) or result pending.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, busy=0.
- A reset assertion mid-frame discards everything immediately.
- Accept: a sample is accepted on a rising clk edge when in_valid && in_ready.
- in_ready = (state != HOLD) || out_ready, so back-to-back frames run with no bubble.
- Term (combinational, truncated to WIDTH):
  - MODE0: (x+y) mod 2^WIDTH.
  - MODE1: low WIDTH bits of x*y.
  - MODE2: (x-y) mod 2^WIDTH.
- acc accumulates terms modulo 2^WIDTH. The first sample of a frame loads acc with the term rather than adding to it.
- States:
  - IDLE: on accept with COUNT>1, load acc, cnt=1 -> ACCUM. On accept with COUNT=1, out_data=term, out_valid=1 -> HOLD.
  - ACCUM: on accept, if cnt==COUNT-1 then out_data=acc+term, out_valid=1, cnt=0 -> HOLD; else acc+=term, cnt++.
  - HOLD: out_data stable while out_valid && !out_ready.
    - On out_ready without an accept: out_valid=0 -> IDLE.
    - On out_ready with a simultaneous accept: treated as the IDLE-accept case in the same cycle, so out_valid stays 1 when COUNT=1.
- Latency: out_valid rises on the clock edge that accepts the COUNT-th sample.
- Abort:
  - in_abort in IDLE/ACCUM clears acc and cnt -> IDLE. Any sample presented in the same cycle is discarded (abort wins).
  - in_abort in HOLD does not affect the pending result.
  - An abort-coincident accept in HOLD (with out_ready) is also discarded.
- busy = (state==ACCUM) || (state==HOLD).

Optional Feature:
- Macro: MODE_ACCUMULATOR_SAT_EN.
- When defined: term and accumulation saturate (unsigned).
  - Add/accumulate clamp to 2^WIDTH-1.
  - Multiply clamps when the product exceeds WIDTH bits.
  - Subtract clamps to 0 when y > x.
- When undefined: pure modulo-2^WIDTH wrap as above. No extra logic is present.

Decomposition:
- Package mode_accumulator_pkg holds:
  - constants MODE_ADD=0, MODE_MUL=1, MODE_SUB=2;
  - the state enum typedef (IDLE, ACCUM, HOLD);
  - a function-free constant for the state width.
- Sub-module mode_accumulator_term: combinational term unit. It contains the generate-if on MODE (if / else if / else with the elaboration error) and the saturation variant under the macro.
- The top level holds the FSM, counter (width $clog2(COUNT+1)), acc and output register.

Test Plan:
- WIDTH=8, MODE=0, COUNT=4; samples (1,2),(3,4),(5,6),(7,8), out_ready=1 -> out_valid one cycle with out_data=36 after the 4th accept; busy then 0.
- WIDTH=8, MODE=1, COUNT=2; (16,16),(3,5) -> out_data=15 without macro; out_data=255 with MODE_ACCUMULATOR_SAT_EN.
- WIDTH=8, MODE=0, COUNT=2; (200,50),(10,0) -> out_data=4 (wrap) without macro; 255 with macro.
- MODE=2, COUNT=1, out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable.
  - Then out_ready=1 with a new sample (9,4) -> the first result is taken and out_valid stays 1 with out_data=5 next cycle.
- MODE=0, COUNT=4; two samples accepted, then in_abort=1 coincident with in_valid -> cnt=0, busy=0.
  - The next frame (1,1)x4 yields out_data=8.
- rst_n pulsed low mid-ACCUM, asynchronous to clk -> out_valid, busy, out_data drop to 0 immediately.
  - The next full frame produces the correct result.
